// File: rtl/d5m_frame_generator_pkg.sv
// Shared types and constants for the synthetic D5M frame source.
package generic_pack;

    typedef enum logic [2:0] {
        StIdle,
        StVlead,
        StActive,
        StHblank,
        StVgap,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        PatRamp,
        PatBars,
        PatChecker,
        PatConst
    } pattern_e;

    // {R,G,B} enables: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [2:0] BarMask [8] = '{
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

endpackage

// File: rtl/d5m_frame_generator_pattern.sv
// Combinational test-pattern lookup: (mode, x, y, bar index, constant colour) to {R,G,B}.
module frame_pattern_gen
    import generic_pack::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CORD_WIDTH = 16
) (
    input  pattern_e                mode_i,
    input  logic [CORD_WIDTH-1:0]   x_i,
    input  logic [CORD_WIDTH-1:0]   y_i,
    input  logic [2:0]              bar_idx_i,
    input  logic [3*DATA_WIDTH-1:0] rgb_i,
    output logic [3*DATA_WIDTH-1:0] rgb_o
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned SW = (DATA_WIDTH > CORD_WIDTH) ? DATA_WIDTH : CORD_WIDTH;

    logic [SW-1:0] x_ext;
    logic [SW-1:0] y_ext;
    logic [SW-1:0] sum;
    logic [2:0]    mask;
    logic          chk;
    logic          unused_bits;

    assign x_ext       = SW'(x_i);
    assign y_ext       = SW'(y_i);
    assign sum         = x_ext + y_ext;
    assign mask        = BarMask[bar_idx_i];
    assign chk         = x_i[3] ^ y_i[3];
    // Ramp keeps only the low DW bits of each coordinate term
    assign unused_bits = ^{x_ext, y_ext, sum};

    always_comb begin
        rgb_o = '0;
        unique case (mode_i)
            PatRamp:    rgb_o = {x_ext[DW-1:0], y_ext[DW-1:0], sum[DW-1:0]};
            PatBars:    rgb_o = {{DW{mask[2]}}, {DW{mask[1]}}, {DW{mask[0]}}};
            PatChecker: rgb_o = {(3*DW){chk}};
            PatConst:   rgb_o = rgb_i;
            default:    rgb_o = '0;
        endcase
    end

endmodule

// File: rtl/d5m_frame_generator.sv
// Synthetic D5M camera source: frame/line timing FSM, coordinates, frame counting and
// registered test-pattern pixels.
module d5m_frame_generator
    import generic_pack::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_WIDTH  = 64,
    parameter int unsigned IMG_HEIGHT = 48,
    parameter int unsigned H_BLANK    = 8,
    parameter int unsigned V_BLANK    = 4,
    parameter int unsigned FRAMES     = 0,
    parameter int unsigned CORD_WIDTH = 16
) (
    input  logic                    pixclk,
    input  logic                    reset,
    input  logic                    iReadyToRead,
    input  logic [1:0]              iImageTypeTest,
    input  logic [3*DATA_WIDTH-1:0] iRgb,
    output logic                    fvalid,
    output logic                    lvalid,
    output logic                    valid,
    output logic [DATA_WIDTH-1:0]   red,
    output logic [DATA_WIDTH-1:0]   green,
    output logic [DATA_WIDTH-1:0]   blue,
    output logic [3*DATA_WIDTH-1:0] rgb,
    output logic [CORD_WIDTH-1:0]   xCord,
    output logic [CORD_WIDTH-1:0]   yCord,
    output logic                    endOfFrame,
    output logic [15:0]             frameCnt,
    output logic                    busy
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned CW = CORD_WIDTH;

    localparam logic [CW-1:0] LastX   = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] LastY   = CW'(IMG_HEIGHT - 1);
    localparam logic [15:0]   VbLast  = 16'(V_BLANK - 1);
    localparam logic [15:0]   HbLast  = 16'(H_BLANK - 1);
    localparam logic [15:0]   BarLast = 16'((IMG_WIDTH / 8) - 1);
    localparam logic [15:0]   FramesC = 16'(FRAMES);

    state_e          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [CW-1:0]   x_q, x_d;
    logic [CW-1:0]   y_q, y_d;
    logic [15:0]     bar_cnt_q, bar_cnt_d;
    logic [2:0]      bar_idx_q, bar_idx_d;
    pattern_e        mode_q, mode_d;
    logic [3*DW-1:0] rgb_lat_q, rgb_lat_d;
    logic [15:0]     run_cnt_q, run_cnt_d;
    logic            enter_vlead;

    logic            fvalid_q, fvalid_d;
    logic            lvalid_q, lvalid_d;
    logic            eof_q, eof_d;
    logic            busy_q, busy_d;
    logic [3*DW-1:0] pix_q, pix_d;
    logic [CW-1:0]   xo_q, xo_d;
    logic [CW-1:0]   yo_q, yo_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic [3*DW-1:0] pat_rgb;

    frame_pattern_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .CORD_WIDTH (CORD_WIDTH)
    ) u_pattern (
        .mode_i    (mode_q),
        .x_i       (x_q),
        .y_i       (y_q),
        .bar_idx_i (bar_idx_q),
        .rgb_i     (rgb_lat_q),
        .rgb_o     (pat_rgb)
    );

    // Timing FSM and coordinate/bar counters
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        bar_cnt_d   = bar_cnt_q;
        bar_idx_d   = bar_idx_q;
        mode_d      = mode_q;
        rgb_lat_d   = rgb_lat_q;
        run_cnt_d   = run_cnt_q;
        enter_vlead = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (iReadyToRead) begin
                    state_d     = StVlead;
                    enter_vlead = 1'b1;
                    run_cnt_d   = '0;
                end
            end
            StVlead: begin
                if (cnt_q == VbLast) begin
                    state_d = StActive;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StActive: begin
                if (x_q == LastX) begin
                    cnt_d = '0;
                    if (y_q == LastY) begin
                        state_d   = StVgap;
                        run_cnt_d = run_cnt_q + 16'd1;
                    end else begin
                        state_d = StHblank;
                    end
                end else begin
                    x_d = x_q + CW'(1);
                    if (bar_cnt_q == BarLast) begin
                        bar_cnt_d = '0;
                        bar_idx_d = bar_idx_q + 3'd1;
                    end else begin
                        bar_cnt_d = bar_cnt_q + 16'd1;
                    end
                end
            end
            StHblank: begin
                if (cnt_q == HbLast) begin
                    state_d   = StActive;
                    cnt_d     = '0;
                    x_d       = '0;
                    y_d       = y_q + CW'(1);
                    bar_cnt_d = '0;
                    bar_idx_d = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StVgap: begin
                if (cnt_q == VbLast) begin
                    if ((FRAMES != 0) && (run_cnt_q == FramesC)) begin
                        state_d = StDone;
                    end else if (!iReadyToRead) begin
                        state_d = StIdle;
                    end else begin
                        state_d     = StVlead;
                        enter_vlead = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StDone: begin
                if (!iReadyToRead) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Mode and colour are sampled only at frame start so a frame is never mixed
        if (enter_vlead) begin
            cnt_d     = '0;
            x_d       = '0;
            y_d       = '0;
            bar_cnt_d = '0;
            bar_idx_d = '0;
            mode_d    = pattern_e'(iImageTypeTest);
            rgb_lat_d = iRgb;
        end
    end

    // Output stage registers the current state, so everything is one cycle behind state_q
    always_comb begin
        fvalid_d    = (state_q == StVlead) || (state_q == StActive) || (state_q == StHblank);
        lvalid_d    = (state_q == StActive);
        busy_d      = (state_q != StIdle) && (state_q != StDone);
        eof_d       = (state_q == StActive) && (x_q == LastX) && (y_q == LastY);
        pix_d       = lvalid_d ? pat_rgb : '0;
        xo_d        = x_q;
        yo_d        = y_q;
        frame_cnt_d = frame_cnt_q + {15'd0, eof_q};
    end

    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            bar_cnt_q   <= '0;
            bar_idx_q   <= '0;
            mode_q      <= PatRamp;
            rgb_lat_q   <= '0;
            run_cnt_q   <= '0;
            fvalid_q    <= 1'b0;
            lvalid_q    <= 1'b0;
            eof_q       <= 1'b0;
            busy_q      <= 1'b0;
            pix_q       <= '0;
            xo_q        <= '0;
            yo_q        <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            bar_cnt_q   <= bar_cnt_d;
            bar_idx_q   <= bar_idx_d;
            mode_q      <= mode_d;
            rgb_lat_q   <= rgb_lat_d;
            run_cnt_q   <= run_cnt_d;
            fvalid_q    <= fvalid_d;
            lvalid_q    <= lvalid_d;
            eof_q       <= eof_d;
            busy_q      <= busy_d;
            pix_q       <= pix_d;
            xo_q        <= xo_d;
            yo_q        <= yo_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign fvalid     = fvalid_q;
    assign lvalid     = lvalid_q;
    assign valid      = lvalid_q;
    assign rgb        = pix_q;
    assign red        = pix_q[3*DW-1:2*DW];
    assign green      = pix_q[2*DW-1:DW];
    assign blue       = pix_q[DW-1:0];
    assign xCord      = xo_q;
    assign yCord      = yo_q;
    assign endOfFrame = eof_q;
    assign frameCnt   = frame_cnt_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_d5m_frame_generator.sv
// Directed bench for d5m_frame_generator: timing, patterns, single-shot and reset behaviour.
module tb_d5m_frame_generator;

    localparam int unsigned W  = 16;
    localparam int unsigned H  = 4;
    localparam int unsigned HB = 2;
    localparam int unsigned VB = 3;
    localparam int unsigned W2 = 64;
    localparam int unsigned H2 = 16;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        ready    = 1'b0;
    logic        ready_ss = 1'b0;
    logic        ready2   = 1'b0;
    logic [1:0]  mode     = 2'd0;
    logic [1:0]  mode_ss  = 2'd0;
    logic [1:0]  mode2    = 2'd0;
    logic [23:0] irgb     = 24'h0;

    always #5 clk = ~clk;

    logic        m_fv, m_lv, m_val, m_eof, m_busy;
    logic [7:0]  m_r, m_g, m_b;
    logic [23:0] m_rgb;
    logic [15:0] m_x, m_y, m_fc;
    logic        s_fv, s_lv, s_val, s_eof, s_busy;
    logic [7:0]  s_r, s_g, s_b;
    logic [23:0] s_rgb;
    logic [15:0] s_x, s_y, s_fc;
    logic        b_fv, b_lv, b_val, b_eof, b_busy;
    logic [7:0]  b_r, b_g, b_b;
    logic [23:0] b_rgb;
    logic [15:0] b_x, b_y, b_fc;

    d5m_frame_generator #(
        .DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .H_BLANK(HB), .V_BLANK(VB),
        .FRAMES(0), .CORD_WIDTH(16)
    ) dut (
        .pixclk(clk), .reset(rst), .iReadyToRead(ready), .iImageTypeTest(mode), .iRgb(irgb),
        .fvalid(m_fv), .lvalid(m_lv), .valid(m_val), .red(m_r), .green(m_g), .blue(m_b),
        .rgb(m_rgb), .xCord(m_x), .yCord(m_y), .endOfFrame(m_eof), .frameCnt(m_fc),
        .busy(m_busy)
    );

    d5m_frame_generator #(
        .DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .H_BLANK(HB), .V_BLANK(VB),
        .FRAMES(2), .CORD_WIDTH(16)
    ) dut_ss (
        .pixclk(clk), .reset(rst), .iReadyToRead(ready_ss), .iImageTypeTest(mode_ss),
        .iRgb(irgb), .fvalid(s_fv), .lvalid(s_lv), .valid(s_val), .red(s_r), .green(s_g),
        .blue(s_b), .rgb(s_rgb), .xCord(s_x), .yCord(s_y), .endOfFrame(s_eof),
        .frameCnt(s_fc), .busy(s_busy)
    );

    d5m_frame_generator #(
        .DATA_WIDTH(8), .IMG_WIDTH(W2), .IMG_HEIGHT(H2), .H_BLANK(HB), .V_BLANK(VB),
        .FRAMES(0), .CORD_WIDTH(16)
    ) dut_big (
        .pixclk(clk), .reset(rst), .iReadyToRead(ready2), .iImageTypeTest(mode2), .iRgb(irgb),
        .fvalid(b_fv), .lvalid(b_lv), .valid(b_val), .red(b_r), .green(b_g), .blue(b_b),
        .rgb(b_rgb), .xCord(b_x), .yCord(b_y), .endOfFrame(b_eof), .frameCnt(b_fc),
        .busy(b_busy)
    );

    // Main-instance monitor
    int   ncyc = 0, rises = 0, falls = 0, eofs = 0, fv_len = 0, lv_len = 0;
    logic fv_prev = 1'b0, lv_prev = 1'b0, eof_prev = 1'b0;
    int   rise_cyc [8]   = '{default: 0};
    int   fv_lens [8]    = '{default: 0};
    int   bursts_ok [8]  = '{default: 0};
    int   bursts_bad [8] = '{default: 0};
    int   eof_x [8]      = '{default: -1};
    int   eof_y [8]      = '{default: -1};
    int   fc_after [8]   = '{default: -1};
    int   zero_viol = 0, valid_viol = 0, chan_viol = 0, eof_viol = 0;
    logic [23:0] mem [4][H][W] = '{default: 24'hAAAAAA};

    always @(negedge clk) begin
        ncyc     <= ncyc + 1;
        fv_prev  <= m_fv;
        lv_prev  <= m_lv;
        eof_prev <= m_eof;
        if (m_fv && !fv_prev) begin
            if (rises < 8) rise_cyc[rises] <= ncyc;
            rises <= rises + 1;
        end
        if (m_fv) fv_len <= fv_prev ? fv_len + 1 : 1;
        if (!m_fv && fv_prev) begin
            if (falls < 8) fv_lens[falls] <= fv_len;
            falls <= falls + 1;
        end
        if (m_lv) lv_len <= lv_prev ? lv_len + 1 : 1;
        if (!m_lv && lv_prev && rises >= 1 && rises <= 8) begin
            if (lv_len == W) bursts_ok[rises-1] <= bursts_ok[rises-1] + 1;
            else bursts_bad[rises-1] <= bursts_bad[rises-1] + 1;
        end
        if (m_lv && m_x < W && m_y < H && rises >= 1 && rises <= 4)
            mem[rises-1][m_y][m_x] <= m_rgb;
        if (!m_lv && m_rgb != 24'h0) zero_viol <= zero_viol + 1;
        if (m_val != m_lv) valid_viol <= valid_viol + 1;
        if ({m_r, m_g, m_b} != m_rgb) chan_viol <= chan_viol + 1;
        if (m_eof) begin
            if (eofs < 8) begin
                eof_x[eofs] <= int'(m_x);
                eof_y[eofs] <= int'(m_y);
            end
            eofs <= eofs + 1;
            if (eof_prev || !m_lv) eof_viol <= eof_viol + 1;
        end
        if (eof_prev && eofs >= 1 && eofs <= 8) fc_after[eofs-1] <= int'(m_fc);
    end

    // Single-shot and large-frame instance monitors
    int   s_rises = 0, b_rises = 0;
    logic s_prev = 1'b0, b_prev = 1'b0;
    logic [23:0] mem2 [2][H2][W2] = '{default: 24'hAAAAAA};

    always @(negedge clk) begin
        s_prev <= s_fv;
        b_prev <= b_fv;
        if (s_fv && !s_prev) s_rises <= s_rises + 1;
        if (b_fv && !b_prev) b_rises <= b_rises + 1;
        if (b_lv && b_x < W2 && b_y < H2 && b_rises >= 1 && b_rises <= 2)
            mem2[b_rises-1][b_y][b_x] <= b_rgb;
    end

    int total = 0, passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    typedef struct {
        string       name;
        int          inst;
        int          frm;
        int          x;
        int          y;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected the run to complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [23:0] act;

        vecs.push_back('{"ramp_0_0",      0, 0,  0,  0, 24'h000000});
        vecs.push_back('{"ramp_5_2",      0, 0,  5,  2, 24'h050207});
        vecs.push_back('{"ramp_7_1",      0, 0,  7,  1, 24'h070108});
        vecs.push_back('{"ramp_15_0",     0, 0, 15,  0, 24'h0F000F});
        vecs.push_back('{"ramp_15_3",     0, 0, 15,  3, 24'h0F0312});
        vecs.push_back('{"const_0_0",     0, 1,  0,  0, 24'h123456});
        vecs.push_back('{"const_5_2",     0, 1,  5,  2, 24'h123456});
        vecs.push_back('{"const_15_3",    0, 1, 15,  3, 24'h123456});
        vecs.push_back('{"bars_0_0",      1, 0,  0,  0, 24'hFFFFFF});
        vecs.push_back('{"bars_7_0",      1, 0,  7,  0, 24'hFFFFFF});
        vecs.push_back('{"bars_8_0",      1, 0,  8,  0, 24'hFFFF00});
        vecs.push_back('{"bars_15_0",     1, 0, 15,  0, 24'hFFFF00});
        vecs.push_back('{"bars_16_0",     1, 0, 16,  0, 24'h00FFFF});
        vecs.push_back('{"bars_24_0",     1, 0, 24,  0, 24'h00FF00});
        vecs.push_back('{"bars_32_0",     1, 0, 32,  0, 24'hFF00FF});
        vecs.push_back('{"bars_40_3",     1, 0, 40,  3, 24'hFF0000});
        vecs.push_back('{"bars_48_2",     1, 0, 48,  2, 24'h0000FF});
        vecs.push_back('{"bars_63_0",     1, 0, 63,  0, 24'h000000});
        vecs.push_back('{"bars_8_15",     1, 0,  8, 15, 24'hFFFF00});
        vecs.push_back('{"checker_8_0",   1, 1,  8,  0, 24'hFFFFFF});
        vecs.push_back('{"checker_8_8",   1, 1,  8,  8, 24'h000000});
        vecs.push_back('{"checker_0_8",   1, 1,  0,  8, 24'hFFFFFF});
        vecs.push_back('{"checker_0_0",   1, 1,  0,  0, 24'h000000});

        // Reset state
        wait_cycles(2);
        check("reset_ctl", {m_fv, m_lv, m_val, m_eof, m_busy, m_fc, m_x, m_y}, 64'h0);
        check("reset_data", {m_rgb, m_r, m_g, m_b}, 64'h0);
        rst = 1'b0;
        wait_cycles(3);
        check("idle_no_frame", {m_fv, m_busy}, 64'h0);

        // Start latency: sampled at edge n, fvalid at n+1, first pixel at n+1+VB
        ready = 1'b1;
        mode  = 2'd0;
        @(negedge clk);
        check("lat_fvalid_n", m_fv, 64'd0);
        @(negedge clk);
        check("lat_fvalid_n1", {m_fv, m_busy, m_lv}, 64'b110);
        wait_cycles(2);
        check("lat_lvalid_n3", m_lv, 64'd0);
        @(negedge clk);
        check("lat_first_pixel", {m_lv, m_x, m_y}, {1'b1, 16'd0, 16'd0});

        // Mode change mid-frame only takes effect on the next frame
        mode = 2'd3;
        irgb = 24'h123456;
        for (int i = 0; i < 200 && rises < 2; i++) @(negedge clk);
        check("frame2_started", rises, 64'd2);
        ready = 1'b0;
        for (int i = 0; i < 200 && falls < 2; i++) @(negedge clk);
        check("frame2_ended", falls, 64'd2);
        wait_cycles(100);
        check("stop_no_restart", rises, 64'd2);
        check("stop_idle", {m_fv, m_busy}, 64'h0);
        check("frame_cnt_2", m_fc, 64'd2);
        check("fvalid_len_f1", fv_lens[0], 64'd73);
        check("fvalid_len_f2", fv_lens[1], 64'd73);
        check("frame_period", rise_cyc[1] - rise_cyc[0], 64'd76);
        check("bursts_f1", {bursts_ok[0], bursts_bad[0]}, {32'd4, 32'd0});
        check("bursts_f2", {bursts_ok[1], bursts_bad[1]}, {32'd4, 32'd0});
        check("eof_count", eofs, 64'd2);
        check("eof_coord_f1", {eof_x[0], eof_y[0]}, {32'd15, 32'd3});
        check("eof_coord_f2", {eof_x[1], eof_y[1]}, {32'd15, 32'd3});
        check("frame_cnt_after_eof1", fc_after[0], 64'd1);
        check("frame_cnt_after_eof2", fc_after[1], 64'd2);

        // Asynchronous reset in the middle of a line
        ready = 1'b1;
        for (int i = 0; i < 100 && !(m_lv && m_x == 16'd7); i++) @(negedge clk);
        check("reached_x7", {m_lv, m_x}, {1'b1, 16'd7});
        rst = 1'b1;
        #1;
        check("async_reset_ctl", {m_fv, m_lv, m_val, m_eof, m_busy, m_fc, m_x, m_y}, 64'h0);
        check("async_reset_data", {m_rgb, m_r, m_g, m_b}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (!m_lv && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("restart_latency", n, 64'd5);
        check("restart_origin", {m_x, m_y, m_fc}, 48'h0);
        ready = 1'b0;
        for (int i = 0; i < 200 && (m_fv || m_busy); i++) @(negedge clk);
        check("restart_frame_done", {m_fv, m_busy}, 64'h0);
        check("restart_frame_cnt", m_fc, 64'd1);

        // Single-shot: two frames then DONE until iReadyToRead drops
        ready_ss = 1'b1;
        for (int i = 0; i < 400 && !(s_rises == 2 && !s_busy); i++) @(negedge clk);
        wait_cycles(150);
        check("ss_run1_frames", s_rises, 64'd2);
        check("ss_run1_done", {s_fv, s_busy}, 64'h0);
        check("ss_run1_cnt", s_fc, 64'd2);
        ready_ss = 1'b0;
        wait_cycles(3);
        ready_ss = 1'b1;
        for (int i = 0; i < 400 && !(s_rises == 4 && !s_busy); i++) @(negedge clk);
        wait_cycles(150);
        check("ss_run2_frames", s_rises, 64'd4);
        check("ss_run2_done", {s_fv, s_busy}, 64'h0);
        check("ss_run2_cnt", s_fc, 64'd4);
        ready_ss = 1'b0;

        // Colour bars on frame 1, checkerboard selected mid-frame for frame 2
        mode2  = 2'd1;
        ready2 = 1'b1;
        for (int i = 0; i < 20 && !b_lv; i++) @(negedge clk);
        check("big_started", b_lv, 64'd1);
        mode2 = 2'd2;
        for (int i = 0; i < 1200 && b_rises < 2; i++) @(negedge clk);
        check("big_frame2_started", b_rises, 64'd2);
        ready2 = 1'b0;
        for (int i = 0; i < 1200 && (b_fv || b_busy); i++) @(negedge clk);
        check("big_done", {b_fv, b_busy, b_fc}, {1'b0, 1'b0, 16'd2});

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].inst == 0) act = mem[vecs[i].frm][vecs[i].y][vecs[i].x];
            else act = mem2[vecs[i].frm][vecs[i].y][vecs[i].x];
            check(vecs[i].name, act, vecs[i].exp);
        end

        check("zero_outside_lvalid", zero_viol, 64'd0);
        check("valid_eq_lvalid", valid_viol, 64'd0);
        check("channels_eq_rgb", chan_viol, 64'd0);
        check("eof_single_pulse", eof_viol, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
